instr_issue_ctrl: RTL and testbench

INSTR_ISSUE_CTRL -- requirements
Module: instr_issue_ctrl

---
 rtl/instr_issue_ctrl_pkg.sv | 32 +++
 rtl/instr_issue_ctrl_fifo.sv | 82 ++++++++
 rtl/instr_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_instr_issue_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_issue_ctrl_pkg.sv
// Shared definitions for the instruction issue controller: idle word, FSM
// state encoding and RISC-V base opcode constants.
package instr_issue_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_J    = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_L    = 7'b0000011;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  // True for words that can redirect the fetch stream.
  function automatic logic is_ctrl_flow(input logic [31:0] instr);
    return (opcode_of(instr) == OPC_B) || (opcode_of(instr) == OPC_J) ||
           (opcode_of(instr) == OPC_JALR);
  endfunction

endpackage

// File: rtl/instr_issue_ctrl_fifo.sv
// Power-of-two instruction queue with push/pop/flush, occupancy count and
// full/empty flags; flush has priority over any push or pop.
module instr_fifo
  import instr_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push_s  = push_i && !full_o && !flush_i;
  assign do_pop_s   = pop_i && !empty_o && !flush_i;
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Instruction issue controller: queues loader words and presents them to the
// cpu one at a time, each held for a programmable number of extra cycles.
module instr_issue_ctrl
  import instr_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = instr_issue_ctrl_pkg::NOP_INSTR,
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic [2:0]  hold_cycles,
  input  logic        redirect,
  output logic [31:0] cpu_instruction,
  output logic        cpu_instruction_RDY_BSY,
  output logic [15:0] issue_count,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        rdy_q, rdy_d;
  logic [15:0] issue_count_q, issue_count_d;
  logic [2:0]  hold_q, hold_d;
  logic        issue_next_s;
  logic        fifo_push_s;
  logic [31:0] fifo_data_s;
  logic [CW-1:0] fifo_count_s;
  logic        fifo_full_s, fifo_empty_s;
  logic        in_ready_s;

  // Acceptance uses registered occupancy only, never a same-cycle pop.
  assign in_ready_s  = !fifo_full_s && !redirect && (state_q != FLUSH);
  assign fifo_push_s = in_valid && in_ready_s;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i       (cpu_clk),
    .rst_i       (cpu_rst),
    .push_i      (fifo_push_s),
    .push_data_i (in_instr),
    .pop_i       (issue_next_s),
    .flush_i     (redirect),
    .pop_data_o  (fifo_data_s),
    .count_o     (fifo_count_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  // Issue FSM next-state, output register and counter updates.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    rdy_d         = 1'b0;
    issue_count_d = issue_count_q;
    hold_d        = hold_q;
    issue_next_s  = 1'b0;
    if (redirect) begin
      state_d = FLUSH;
      instr_d = NOP_INSTR;
      hold_d  = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty_s) begin
            issue_next_s = 1'b1;
          end else begin
            instr_d = NOP_INSTR;
          end
        end
        ISSUE: begin
          if (hold_cycles != 3'd0) begin
            state_d = HOLD;
            hold_d  = hold_cycles;
          end else if (!fifo_empty_s) begin
            issue_next_s = 1'b1;
          end else begin
            state_d = IDLE;
            instr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (hold_q > 3'd1) begin
            hold_d = hold_q - 3'd1;
          end else begin
            hold_d = 3'd0;
            if (!fifo_empty_s) begin
              issue_next_s = 1'b1;
            end else begin
              state_d = IDLE;
              instr_d = NOP_INSTR;
            end
          end
        end
        FLUSH: begin
          state_d = IDLE;
          instr_d = NOP_INSTR;
        end
        default: begin
          state_d = IDLE;
          instr_d = NOP_INSTR;
          hold_d  = 3'd0;
        end
      endcase
      if (issue_next_s) begin
        state_d       = ISSUE;
        instr_d       = fifo_data_s;
        rdy_d         = 1'b1;
        issue_count_d = issue_count_q + 16'd1;
      end else begin
        rdy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q       <= IDLE;
      instr_q       <= NOP_INSTR;
      rdy_q         <= 1'b0;
      issue_count_q <= 16'd0;
      hold_q        <= 3'd0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      rdy_q         <= rdy_d;
      issue_count_q <= issue_count_d;
      hold_q        <= hold_d;
    end
  end

  assign in_ready                = in_ready_s;
  assign cpu_instruction         = instr_q;
  assign cpu_instruction_RDY_BSY = rdy_q;
  assign issue_count             = issue_count_q;
  assign busy                    = (state_q != IDLE) || (fifo_count_s != '0);

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl: a vector table for queueing, holding
// and back-pressure, plus hand sequences for redirect, async reset and wrap.
module tb_instr_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A   = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] P   = 32'h0070_0113;  // addi x2,x0,7
  localparam logic [31:0] W0  = 32'h0020_81B3;  // add  x3,x1,x2
  localparam logic [31:0] W1  = 32'h4020_8233;  // sub  x4,x1,x2
  localparam logic [31:0] W2  = 32'h0031_2023;  // sw   x3,0(x2)
  localparam logic [31:0] W3  = 32'h0001_2283;  // lw   x5,0(x2)
  localparam logic [31:0] W4  = 32'h0000_006F;  // jal  x0,0
  localparam logic [31:0] X0  = 32'h0010_0313;
  localparam logic [31:0] X1  = 32'h0020_0393;
  localparam logic [31:0] X2  = 32'h0030_0413;
  localparam logic [31:0] X3  = 32'h0040_0493;
  localparam logic [31:0] Y   = 32'h0050_0513;
  localparam logic [31:0] Z   = 32'h0060_0593;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic        in_ready;
  logic [2:0]  hold_cycles = 3'd0;
  logic        redirect = 1'b0;
  logic [31:0] cpu_instruction;
  logic        cpu_instruction_RDY_BSY;
  logic [15:0] issue_count;
  logic        busy;

  int tests = 0;
  int fails = 0;

  instr_issue_ctrl #(.DEPTH(4), .NOP_INSTR(32'h0000_0013)) dut (
    .cpu_clk                 (cpu_clk),
    .cpu_rst                 (cpu_rst),
    .in_valid                (in_valid),
    .in_instr                (in_instr),
    .in_ready                (in_ready),
    .hold_cycles             (hold_cycles),
    .redirect                (redirect),
    .cpu_instruction         (cpu_instruction),
    .cpu_instruction_RDY_BSY (cpu_instruction_RDY_BSY),
    .issue_count             (issue_count),
    .busy                    (busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [2:0]  h;
    logic        r;
    logic        e_ready;
    logic [31:0] e_instr;
    logic        e_pulse;
    logic [15:0] e_cnt;
    logic        e_busy;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] h, input logic r);
    in_valid    = v;
    in_instr    = d;
    hold_cycles = h;
    redirect    = r;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ei, input logic ep,
                         input logic [15:0] ec, input logic eb);
    chk({tag, ".instr"}, cpu_instruction, ei);
    chk({tag, ".rdy"}, {31'd0, cpu_instruction_RDY_BSY}, {31'd0, ep});
    chk({tag, ".cnt"}, {16'd0, issue_count}, {16'd0, ec});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
  endtask

  initial begin
    //            v     d    h     r     ready instr pulse cnt    busy
    tbl[0]  = '{1'b1, A,   3'd3, 1'b0, 1'b1, NOP, 1'b0, 16'd0, 1'b1};
    tbl[1]  = '{1'b0, 0,   3'd3, 1'b0, 1'b1, A,   1'b1, 16'd1, 1'b1};
    tbl[2]  = '{1'b0, 0,   3'd3, 1'b0, 1'b1, A,   1'b0, 16'd1, 1'b1};
    tbl[3]  = '{1'b0, 0,   3'd3, 1'b0, 1'b1, A,   1'b0, 16'd1, 1'b1};
    tbl[4]  = '{1'b0, 0,   3'd3, 1'b0, 1'b1, A,   1'b0, 16'd1, 1'b1};
    tbl[5]  = '{1'b0, 0,   3'd3, 1'b0, 1'b1, NOP, 1'b0, 16'd1, 1'b0};
    tbl[6]  = '{1'b1, P,   3'd7, 1'b0, 1'b1, NOP, 1'b0, 16'd1, 1'b1};
    tbl[7]  = '{1'b0, 0,   3'd7, 1'b0, 1'b1, P,   1'b1, 16'd2, 1'b1};
    tbl[8]  = '{1'b1, W0,  3'd7, 1'b0, 1'b1, P,   1'b0, 16'd2, 1'b1};
    tbl[9]  = '{1'b1, W1,  3'd7, 1'b0, 1'b1, P,   1'b0, 16'd2, 1'b1};
    tbl[10] = '{1'b1, W2,  3'd7, 1'b0, 1'b1, P,   1'b0, 16'd2, 1'b1};
    tbl[11] = '{1'b1, W3,  3'd7, 1'b0, 1'b1, P,   1'b0, 16'd2, 1'b1};
    tbl[12] = '{1'b1, W4,  3'd7, 1'b0, 1'b0, P,   1'b0, 16'd2, 1'b1};
    tbl[13] = '{1'b1, W4,  3'd7, 1'b0, 1'b0, P,   1'b0, 16'd2, 1'b1};
    tbl[14] = '{1'b0, 0,   3'd0, 1'b0, 1'b0, P,   1'b0, 16'd2, 1'b1};
    tbl[15] = '{1'b0, 0,   3'd0, 1'b0, 1'b0, W0,  1'b1, 16'd3, 1'b1};
    tbl[16] = '{1'b0, 0,   3'd0, 1'b0, 1'b1, W1,  1'b1, 16'd4, 1'b1};
    tbl[17] = '{1'b0, 0,   3'd0, 1'b0, 1'b1, W2,  1'b1, 16'd5, 1'b1};
    tbl[18] = '{1'b0, 0,   3'd0, 1'b0, 1'b1, W3,  1'b1, 16'd6, 1'b1};
    tbl[19] = '{1'b0, 0,   3'd0, 1'b0, 1'b1, NOP, 1'b0, 16'd6, 1'b0};
    tbl[20] = '{1'b0, 0,   3'd0, 1'b0, 1'b1, NOP, 1'b0, 16'd6, 1'b0};

    // Reset state
    #12;
    chk_out("rst_held", NOP, 1'b0, 16'd0, 1'b0);
    cpu_rst = 1'b0;
    tick();
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk_out("rst", NOP, 1'b0, 16'd0, 1'b0);

    // Table: single hold, fill-while-holding, full drop, back-to-back issue
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].h, tbl[i].r);
      #1;
      chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ready});
      tick();
      chk_out($sformatf("v%0d", i), tbl[i].e_instr, tbl[i].e_pulse, tbl[i].e_cnt, tbl[i].e_busy);
    end

    // Redirect during HOLD discards queued words and wins over a push
    drive(1'b1, X0, 3'd2, 1'b0); tick();
    drive(1'b1, X1, 3'd2, 1'b0); tick();
    chk_out("rd_issue", X0, 1'b1, 16'd7, 1'b1);
    drive(1'b1, X2, 3'd2, 1'b0); tick();
    chk_out("rd_hold", X0, 1'b0, 16'd7, 1'b1);
    drive(1'b1, X3, 3'd2, 1'b1);
    #1;
    chk("rd.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk_out("rd_flush", NOP, 1'b0, 16'd7, 1'b1);
    drive(1'b0, 0, 3'd2, 1'b0);
    #1;
    chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk_out("rd_idle", NOP, 1'b0, 16'd7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("rd_quiet%0d", i), NOP, 1'b0, 16'd7, 1'b0);
    end

    // Redirect held high stays in FLUSH
    drive(1'b0, 0, 3'd0, 1'b1); tick(); tick();
    chk_out("rd_held", NOP, 1'b0, 16'd7, 1'b1);
    drive(1'b0, 0, 3'd0, 1'b0); tick();
    chk_out("rd_rel", NOP, 1'b0, 16'd7, 1'b0);

    // Asynchronous reset mid-HOLD
    drive(1'b1, Y, 3'd5, 1'b0); tick();
    drive(1'b0, 0, 3'd5, 1'b0); tick();
    chk_out("ar_issue", Y, 1'b1, 16'd8, 1'b1);
    tick();
    chk_out("ar_hold", Y, 1'b0, 16'd8, 1'b1);
    #2;
    cpu_rst = 1'b1;
    #1;
    chk_out("ar_async", NOP, 1'b0, 16'd0, 1'b0);
    #2;
    cpu_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out($sformatf("ar_after%0d", i), NOP, 1'b0, 16'd0, 1'b0);
    end
    chk("ar.in_ready", {31'd0, in_ready}, 32'd1);

    // issue_count wraps 65535 -> 0
    force dut.issue_count_q = 16'hFFFF;
    tick();
    release dut.issue_count_q;
    tick();
    chk("wrap.preset", {16'd0, issue_count}, 32'h0000_FFFF);
    drive(1'b1, Z, 3'd0, 1'b0); tick();
    drive(1'b0, 0, 3'd0, 1'b0); tick();
    chk_out("wrap_issue", Z, 1'b1, 16'd0, 1'b1);
    tick();
    chk_out("wrap_idle", NOP, 1'b0, 16'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
